// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake for uart_tx_fifo: a data word qualified by valid_in
// and accepted when ready_out is high on the same rising edge.
interface uart_tx_fifo_if #(
  parameter int MESSAGE_WIDTH = 8
);
  logic [MESSAGE_WIDTH-1:0] data_in;
  logic                     valid_in;
  logic                     ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words enter a FIFO through a valid/ready
// handshake and leave LSB-first as start/data/[parity]/stop frames on
// tx_wire_out, back-to-back with no idle gap while words are queued.
// Optional feature macro: UART_TX_PARITY_EN (adds one parity bit after data;
// PARITY_ODD selects odd parity). Without it PARITY_ODD has no effect.
module uart_tx_fifo #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 115_200,
  parameter int MESSAGE_WIDTH    = 8,
  parameter int FIFO_DEPTH       = 8,
  parameter int STOP_BITS        = 1,
  parameter int PARITY_ODD       = 0
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  uart_tx_fifo_if.slave                    bus,
  output logic                             busy_out,
  output logic                             tx_wire_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_out
);

  localparam int CPB = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);
  // Bit index doubles as the stop-bit counter; it always fits STOP_BITS-1.
  localparam int BW  = $clog2(MESSAGE_WIDTH + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(MESSAGE_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [NW-1:0] FULL      = NW'(FIFO_DEPTH);

  // Reject configurations the datapath cannot represent.
  if (CPB < 2 || MESSAGE_WIDTH < 1 || MESSAGE_WIDTH > 32 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_config
    $error("uart_tx_fifo: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [MESSAGE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [NW-1:0]            count;
  logic [MESSAGE_WIDTH-1:0] head;

  state_t                   state;
  logic [CW-1:0]            baud_cnt;
  logic [BW-1:0]            bit_idx;
  logic [MESSAGE_WIDTH-1:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic                     parity_bit;
`endif

  logic baud_wrap;
  logic frame_end;
  logic push;
  logic pop;

  assign bus.ready_out  = !rst_in && (count != FULL);
  assign fifo_count_out = count;
  assign head           = mem[rd_ptr];

  // Handshake and pop decisions shared by the FIFO and the frame sequencer.
  always_comb begin
    baud_wrap = (baud_cnt == BAUD_LAST);
    frame_end = (state == S_STOP) && baud_wrap && (bit_idx == STOP_LAST);
    pop       = (count != '0) && ((state == S_IDLE) || frame_end);
    push      = bus.valid_in && bus.ready_out;
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + NW'(1);
      else if (pop && !push) count <= count - NW'(1);
    end
  end

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      tx_wire_out <= 1'b1;
      busy_out    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      baud_cnt <= (state == S_IDLE || baud_wrap) ? '0 : baud_cnt + CW'(1);
      case (state)
        S_IDLE: begin
          if (pop) begin
            state       <= S_START;
            shreg       <= head;
            tx_wire_out <= 1'b0;
            busy_out    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= (^head) ^ 1'(PARITY_ODD);
`endif
          end
        end
        S_START: begin
          // Drive data[0] now and pre-shift so shreg[0] always holds the next bit.
          if (baud_wrap) begin
            state       <= S_DATA;
            bit_idx     <= '0;
            tx_wire_out <= shreg[0];
            shreg       <= shreg >> 1;
          end
        end
        S_DATA: begin
          if (baud_wrap) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx     <= '0;
`ifdef UART_TX_PARITY_EN
              state       <= S_PARITY;
              tx_wire_out <= parity_bit;
`else
              state       <= S_STOP;
              tx_wire_out <= 1'b1;
`endif
            end else begin
              bit_idx     <= bit_idx + BW'(1);
              tx_wire_out <= shreg[0];
              shreg       <= shreg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_wrap) begin
            state       <= S_STOP;
            bit_idx     <= '0;
            tx_wire_out <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_wrap) begin
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (pop) begin
                state       <= S_START;
                shreg       <= head;
                tx_wire_out <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_bit  <= (^head) ^ 1'(PARITY_ODD);
`endif
              end else begin
                state       <= S_IDLE;
                tx_wire_out <= 1'b1;
                busy_out    <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          tx_wire_out <= 1'b1;
          busy_out    <= 1'b0;
        end
      endcase
    end
  end

endmodule
